// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared constants and state encoding for the window address sequencer
//
// Holds the parameter defaults used by win_addr_seq / win_addr_cnt, the FSM
// state encoding and the derived two-row offset.

package win_pkg;

  localparam int         AW_DEF       = 12;
  localparam int         STRIDE_DEF   = 9;
  localparam logic [5:0] HOLD_OPC_DEF = 6'd5;
  localparam int         SENTINEL_DEF = 4091;

  function automatic int two_stride_of(input int stride);
    return 2 * stride;
  endfunction

  localparam int TWO_STRIDE = two_stride_of(STRIDE_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/win_addr_seq_if.sv
// rtl/win_addr_seq_if.sv - address triple stream between sequencer and consumer
//
// Signals:
//   addr_valid          triple below is valid (master -> slave)
//   addr2/addr3/addr4   top/middle/bottom row tap addresses (master -> slave)
//   addr_ready          consumer accepts the current triple (slave -> master)

interface win_addr_seq_if #(
  parameter int AW = win_pkg::AW_DEF
);

  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] addr2;
  logic [AW-1:0] addr3;
  logic [AW-1:0] addr4;

  modport master (
    output addr_valid,
    output addr2,
    output addr3,
    output addr4,
    input  addr_ready
  );

  modport slave (
    input  addr_valid,
    input  addr2,
    input  addr3,
    input  addr4,
    output addr_ready
  );

endinterface

// File: rtl/win_addr_cnt.sv
// rtl/win_addr_cnt.sv - column/row counters and incremental tap address generator
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   init                load base and zero the counters (scan launch)
//   step                advance to the next triple (accepted handshake)
//   base                start address of row 0, column 0
//   n_cols, n_rows      scan geometry used for the last_col / last_row flags
//   tap2/tap3/tap4      current top/middle/bottom tap addresses
//   over                current triple reaches SENTINEL or wrapped past 2^AW
//   last_col, last_row  current triple is the last of its row / last row

module win_addr_cnt import win_pkg::*; #(
  parameter int            AW       = AW_DEF,
  parameter int            STRIDE   = STRIDE_DEF,
  parameter logic [AW-1:0] SENTINEL = AW'(SENTINEL_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [3:0]    n_cols,
  input  logic [7:0]    n_rows,
  output logic [AW-1:0] tap2,
  output logic [AW-1:0] tap3,
  output logic [AW-1:0] tap4,
  output logic          over,
  output logic          last_col,
  output logic          last_row
);

  localparam logic [AW-1:0] S1 = AW'(STRIDE);
  localparam logic [AW-1:0] S2 = AW'(two_stride_of(STRIDE));

  logic [3:0]    col;
  logic [7:0]    row;
  logic [AW-1:0] row_base;
  logic [AW-1:0] nxt_row_base;
  logic [AW-1:0] nxt_tap;
  logic [AW:0]   nxt_bottom;
  logic          nxt_over;

  assign last_col = (col == n_cols - 4'd1);
  assign last_row = (row == n_rows - 8'd3);

  // Next top-row tap: +1 within a row, row_base + STRIDE at a row change.
  always_comb begin
    nxt_row_base = row_base;
    nxt_tap      = tap2 + AW'(1);
    if (init) begin
      nxt_row_base = base;
      nxt_tap      = base;
    end else if (last_col) begin
      nxt_row_base = row_base + S1;
      nxt_tap      = row_base + S1;
    end
  end

  // The bottom tap is the largest address of a triple, and the unwrapped
  // address sequence only grows, so one extra carry bit on the bottom tap
  // catches both "reached SENTINEL" and "wrapped". If the top tap itself has
  // already wrapped, an earlier bottom tap overflowed and over is already set.
  assign nxt_bottom = {1'b0, nxt_tap} + {1'b0, S2};
  assign nxt_over   = (nxt_bottom >= {1'b0, SENTINEL});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= 4'd0;
      row      <= 8'd0;
      row_base <= '0;
      tap2     <= '0;
      tap3     <= '0;
      tap4     <= '0;
      over     <= 1'b0;
    end else if (init || step) begin
      col      <= (init || last_col) ? 4'd0 : col + 4'd1;
      row      <= init ? 8'd0 : (last_col ? row + 8'd1 : row);
      row_base <= nxt_row_base;
      tap2     <= nxt_tap;
      tap3     <= nxt_tap + S1;
      tap4     <= nxt_tap + S2;
      over     <= nxt_over || (over && !init);
    end
  end

endmodule

// File: rtl/win_addr_seq.sv
// rtl/win_addr_seq.sv - 3-row window address sequencer with handshake, hold and error reporting
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle launch pulse (honoured only in IDLE)
//   base                start address of row 0, column 0
//   n_cols              columns per row, 1..STRIDE
//   n_rows              image rows (window rows = n_rows - 2)
//   abort               synchronous cancel back to IDLE, no done pulse
//   instr_fb            downstream feedback; HOLD_OPC freezes the scan
//   addr_bus            master side of the addr_valid/addr_ready triple stream
//   busy                state is not IDLE
//   done                one-cycle completion pulse
//   err                 sticky error (bad geometry or address >= SENTINEL)

module win_addr_seq import win_pkg::*; #(
  parameter int            AW       = AW_DEF,
  parameter int            STRIDE   = STRIDE_DEF,
  parameter logic [5:0]    HOLD_OPC = HOLD_OPC_DEF,
  parameter logic [AW-1:0] SENTINEL = AW'(SENTINEL_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base,
  input  logic [3:0]            n_cols,
  input  logic [7:0]            n_rows,
  input  logic                  abort,
  input  logic [5:0]            instr_fb,
  win_addr_seq_if.master        addr_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [4:0] MAX_COLS = (STRIDE > 15) ? 5'd15 : 5'(STRIDE);

  state_t        state;
  logic          valid_q;
  logic          err_q;
  logic [3:0]    cfg_cols;
  logic [7:0]    cfg_rows;
  logic          hold;
  logic          addr_valid;
  logic          handshake;
  logic          init;
  logic          step;
  logic          bad_cfg;
  logic          last_col;
  logic          last_row;
  logic          over;
  logic [AW-1:0] tap2;
  logic [AW-1:0] tap3;
  logic [AW-1:0] tap4;

  // The hold opcode masks valid in the same cycle it is seen, so the consumer
  // never observes a handshake that the counters would then ignore.
  assign hold       = (state == ST_RUN) && (instr_fb == HOLD_OPC);
  assign addr_valid = valid_q && !hold;
  assign handshake  = addr_valid && addr_bus.addr_ready;
  assign init       = (state == ST_IDLE) && start;
  assign step       = handshake && !abort;
  assign bad_cfg    = (cfg_rows < 8'd3) || (cfg_cols == 4'd0) ||
                      ({1'b0, cfg_cols} > MAX_COLS);

  win_addr_cnt #(
    .AW       (AW),
    .STRIDE   (STRIDE),
    .SENTINEL (SENTINEL)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (init),
    .step     (step),
    .base     (base),
    .n_cols   (cfg_cols),
    .n_rows   (cfg_rows),
    .tap2     (tap2),
    .tap3     (tap3),
    .tap4     (tap4),
    .over     (over),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      valid_q  <= 1'b0;
      done     <= 1'b0;
      err_q    <= 1'b0;
      cfg_cols <= 4'd0;
      cfg_rows <= 8'd0;
    end else begin
      done  <= 1'b0;
      err_q <= err_q || (addr_valid && over);
      if ((state != ST_IDLE) && abort) begin
        state   <= ST_IDLE;
        valid_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state    <= ST_LOAD;
              cfg_cols <= n_cols;
              cfg_rows <= n_rows;
              err_q    <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (bad_cfg) begin
              err_q <= 1'b1;
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_RUN;
              valid_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (handshake && last_col && last_row) begin
              valid_q <= 1'b0;
              state   <= ST_DONE;
              done    <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign err  = err_q || (addr_valid && over);

  assign addr_bus.addr_valid = addr_valid;
  assign addr_bus.addr2      = tap2;
  assign addr_bus.addr3      = tap3;
  assign addr_bus.addr4      = tap4;

endmodule

// File: tb/tb_win_addr_seq.sv
// tb/tb_win_addr_seq.sv - self-checking bench for win_addr_seq

module tb_win_addr_seq;
  import win_pkg::*;

  typedef struct { int a2; int a3; int a4; bit over; } trip_t;
  typedef struct { int a2; int a3; int a4; int e; } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] base = 12'd0;
  logic [3:0]  n_cols = 4'd0;
  logic [7:0]  n_rows = 8'd0;
  logic [5:0]  instr_fb = 6'd0;
  logic        busy;
  logic        done;
  logic        err;

  win_addr_seq_if #(.AW(12)) bus();

  win_addr_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .n_cols   (n_cols),
    .n_rows   (n_rows),
    .abort    (abort),
    .instr_fb (instr_fb),
    .addr_bus (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Behavioural model: the full triple list is computed up front with plain
  // arithmetic; stage tracks launch / streaming / completion timing.
  trip_t mq[$];
  int    m_stage = 0;
  bit    m_err = 1'b0;
  bit    m_bad = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit shown;
    if (!rst_n) begin
      mq.delete();
      m_stage = 0;
      m_err   = 1'b0;
      m_bad   = 1'b0;
    end else begin
      shown = (m_stage == 2) && (instr_fb != HOLD_OPC_DEF) && (mq.size() > 0);
      if (shown && mq[0].over) m_err = 1'b1;
      if ((m_stage != 0) && abort) begin
        m_stage = 0;
        mq.delete();
      end else begin
        case (m_stage)
          0: if (start) begin
            m_bad = (int'(n_rows) < 3) || (int'(n_cols) == 0) || (int'(n_cols) > STRIDE_DEF);
            m_err = 1'b0;
            mq.delete();
            if (!m_bad) begin
              for (int r = 0; r <= int'(n_rows) - 3; r++) begin
                for (int c = 0; c < int'(n_cols); c++) begin
                  trip_t t;
                  int a;
                  a      = int'(base) + r * STRIDE_DEF + c;
                  t.a2   = a % (1 << AW_DEF);
                  t.a3   = (a + STRIDE_DEF) % (1 << AW_DEF);
                  t.a4   = (a + TWO_STRIDE) % (1 << AW_DEF);
                  t.over = (a + TWO_STRIDE) >= SENTINEL_DEF;
                  mq.push_back(t);
                end
              end
            end
            m_stage = 1;
          end
          1: begin
            if (m_bad) begin
              m_err   = 1'b1;
              m_stage = 3;
            end else begin
              m_stage = 2;
            end
          end
          2: if (shown && bus.addr_ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_stage = 3;
          end
          default: m_stage = 0;
        endcase
      end
    end
  end

  // Observation log for directed literal checks.
  obs_t acc[$];
  obs_t stall[$];
  int   hold_low = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   first_valid_cyc = -1;
  int   cyc = 0;

  always @(negedge clk) begin
    bit   ev;
    obs_t o;
    if (!rst_n) begin
      chk("rst_valid", int'(bus.addr_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_addr2", int'(bus.addr2), 0);
    end else begin
      ev = (m_stage == 2) && (instr_fb != HOLD_OPC_DEF) && (mq.size() > 0);
      chk("valid", int'(bus.addr_valid), int'(ev));
      chk("busy", int'(busy), int'(m_stage != 0));
      chk("done", int'(done), int'(m_stage == 3));
      chk("err", int'(err), int'(m_err || (ev && mq[0].over)));
      if ((m_stage == 2) && (mq.size() > 0)) begin
        chk("addr2", int'(bus.addr2), mq[0].a2);
        chk("addr3", int'(bus.addr3), mq[0].a3);
        chk("addr4", int'(bus.addr4), mq[0].a4);
      end
    end
    o.a2 = int'(bus.addr2);
    o.a3 = int'(bus.addr3);
    o.a4 = int'(bus.addr4);
    o.e  = int'(err);
    if (bus.addr_valid && bus.addr_ready && !abort) acc.push_back(o);
    if (bus.addr_valid && !bus.addr_ready) stall.push_back(o);
    if (busy && !bus.addr_valid && (instr_fb == HOLD_OPC_DEF)) hold_low++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.addr_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
    cyc++;
  end

  int lit41 [18] = '{0, 9, 18, 1, 10, 19, 2, 11, 20, 9, 18, 27, 10, 19, 28, 11, 20, 29};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    acc.delete();
    stall.delete();
    hold_low        = 0;
    done_cnt        = 0;
    done_cyc        = -1;
    first_valid_cyc = -1;
    cyc             = 0;
  endtask

  task automatic launch(input logic [11:0] b, input logic [3:0] c, input logic [7:0] r);
    base   = b;
    n_cols = c;
    n_rows = r;
    start  = 1'b1;
    clear_obs();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && (n < budget)) begin
      tick();
      n++;
    end
    chk("idle_within_budget", int'(busy), 0);
  endtask

  task automatic check_list41(input string nm);
    chk({nm, "_count"}, acc.size(), 6);
    for (int i = 0; i < 6 && i < acc.size(); i++) begin
      chk({nm, "_a2"}, acc[i].a2, lit41[3*i]);
      chk({nm, "_a3"}, acc[i].a3, lit41[3*i+1]);
      chk({nm, "_a4"}, acc[i].a4, lit41[3*i+2]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic scan, start on the first edge after reset release.
    rst_n = 1'b1;
    launch(12'd0, 4'd3, 8'd4);
    wait_idle(60);
    check_list41("t1");
    chk("t1_first_valid_cyc", first_valid_cyc, 2);
    chk("t1_done_cyc", done_cyc, 8);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err", int'(err), 0);

    // Back-pressure on the second triple for three cycles.
    launch(12'd0, 4'd3, 8'd4);
    tick();
    tick();
    bus.addr_ready = 1'b0;
    repeat (3) tick();
    bus.addr_ready = 1'b1;
    wait_idle(60);
    check_list41("t2");
    chk("t2_stall_cycles", stall.size(), 3);
    for (int i = 0; i < stall.size(); i++) begin
      chk("t2_stall_a2", stall[i].a2, 1);
      chk("t2_stall_a3", stall[i].a3, 10);
      chk("t2_stall_a4", stall[i].a4, 19);
    end

    // Hold opcode for four cycles mid-scan.
    launch(12'd0, 4'd3, 8'd4);
    tick();
    tick();
    instr_fb = 6'd5;
    repeat (4) tick();
    instr_fb = 6'd0;
    wait_idle(60);
    check_list41("t3");
    chk("t3_hold_low", hold_low, 4);
    chk("t3_done_cnt", done_cnt, 1);

    // Wrap past the top of the address space.
    launch(12'd4080, 4'd2, 8'd3);
    wait_idle(60);
    chk("t4_count", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("t4_t0_a2", acc[0].a2, 4080);
      chk("t4_t0_a3", acc[0].a3, 4089);
      chk("t4_t0_a4", acc[0].a4, 2);
      chk("t4_t0_err", acc[0].e, 1);
      chk("t4_t1_a2", acc[1].a2, 4081);
      chk("t4_t1_a3", acc[1].a3, 4090);
      chk("t4_t1_a4", acc[1].a4, 3);
    end
    chk("t4_err", int'(err), 1);

    // Too few rows.
    launch(12'd0, 4'd3, 8'd2);
    wait_idle(20);
    chk("t5_count", acc.size(), 0);
    chk("t5_done_cyc", done_cyc, 2);
    chk("t5_first_valid", first_valid_cyc, -1);
    chk("t5_err", int'(err), 1);

    // Abort on the third triple, together with a ready handshake.
    launch(12'd0, 4'd3, 8'd4);
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_valid", int'(bus.addr_valid), 0);
    repeat (3) tick();
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_count", acc.size(), 2);
    chk("t6_err", int'(err), 0);

    // Asynchronous reset mid-scan, then a clean scan.
    launch(12'd0, 4'd3, 8'd4);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", int'(bus.addr_valid), 0);
    chk("t7_busy", int'(busy), 0);
    chk("t7_done", int'(done), 0);
    chk("t7_err", int'(err), 0);
    chk("t7_addr2", int'(bus.addr2), 0);
    chk("t7_addr3", int'(bus.addr3), 0);
    chk("t7_addr4", int'(bus.addr4), 0);
    tick();
    rst_n = 1'b1;
    clear_obs();
    repeat (3) tick();
    chk("t7_no_done", done_cnt, 0);
    launch(12'd0, 4'd3, 8'd4);
    wait_idle(60);
    check_list41("t7");
    chk("t7_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/win_addr_seq.md
WIN_ADDR_SEQ -- requirements
Module: win_addr_seq

Interface
REQ-001 The block SHALL have parameter AW, default 12, meaning the address width.
REQ-002 The block SHALL have parameter STRIDE, default 9, meaning the row pitch in words.
REQ-003 The block SHALL have parameter HOLD_OPC, default 6'd5, meaning the feedback opcode that freezes sequencing.
REQ-004 The block SHALL have parameter SENTINEL, default 12'd4091, meaning the lowest reserved address.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is posedge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port start, input, 1 bit: one-cycle pulse that launches a scan.
REQ-008 Port base, input, AW bits: start address of row 0, column 0.
REQ-009 Port n_cols, input, 4 bits: columns per row, 1..STRIDE.
REQ-010 Port n_rows, input, 8 bits: image rows.
REQ-011 Port abort, input, 1 bit: synchronous cancel.
REQ-012 Port instr_fb, input, 6 bits: downstream instruction feedback.
REQ-013 Port addr_ready, input, 1 bit: consumer accepts the current triple.
REQ-014 Port addr_valid, output, 1 bit: addr2/addr3/addr4 are valid.
REQ-015 Port addr2, output, AW bits: top-row tap address.
REQ-016 Port addr3, output, AW bits: middle-row tap address.
REQ-017 Port addr4, output, AW bits: bottom-row tap address.
REQ-018 Port busy, output, 1 bit: state is not IDLE.
REQ-019 Port done, output, 1 bit: one-cycle completion pulse.
REQ-020 Port err, output, 1 bit: sticky error, cleared by the next accepted start.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-022 IDLE -> LOAD on start; LOAD -> RUN; RUN -> DONE after the last triple is accepted; DONE -> IDLE unconditionally.
REQ-023 In IDLE, start SHALL latch base, n_cols and n_rows; start in any other state SHALL be ignored.
REQ-024 The first addr_valid SHALL assert 2 cycles after start: start sampled at edge t, LOAD at t+1, valid at t+2.
REQ-025 Triple for window row r, column c: addr2 = base + r*STRIDE + c; addr3 = addr2 + STRIDE; addr4 = addr2 + 2*STRIDE; all modulo 2^AW.
REQ-026 Addresses SHALL be formed incrementally from a row-base register with adders only; no multiplier.
REQ-027 Scan order: c = 0..n_cols-1 innermost, then r = 0..n_rows-3; total triples = n_cols*(n_rows-2).
REQ-028 A handshake occurs when addr_valid && addr_ready; the counters SHALL advance only on a handshake.
REQ-029 addr2/3/4 SHALL hold stable while addr_valid && !addr_ready.
REQ-030 While instr_fb == HOLD_OPC in RUN: addr_valid = 0, counters frozen, outputs held; resume on the next cycle after the hold releases.
REQ-031 In LOAD, n_rows < 3, n_cols == 0 or n_cols > STRIDE SHALL set err and go to DONE with no triples.
REQ-032 If any emitted address >= SENTINEL (including after wrap), err SHALL set and the scan SHALL continue unchanged.
REQ-033 abort in any non-IDLE state SHALL go to IDLE next cycle with addr_valid = 0 and no done pulse; abort takes priority over a simultaneous handshake.
REQ-034 done SHALL be high for exactly the one cycle in DONE; busy = (state != IDLE).

Reset
REQ-035 Asserting rst_n low SHALL immediately force state IDLE; addr_valid, done, busy and err to 0; addr2/3/4 and counters to 0.
REQ-036 Reset asserted mid-scan SHALL discard the scan, and no done pulse SHALL follow.
REQ-037 rst_n deassertion SHALL be synchronised externally; the block SHALL accept start on the first edge after release.

Structure
REQ-038 Shared package win_pkg SHALL hold the state encoding, the AW, STRIDE, HOLD_OPC and SENTINEL defaults, and the derived constant TWO_STRIDE.
REQ-039 One sub-module, win_addr_cnt, SHALL hold the column counter, row counter and row-base incrementer and report last_col and last_row.
REQ-040 The FSM, handshake and error logic SHALL reside in win_addr_seq.

Verification
REQ-041 base=0, n_cols=3, n_rows=4, ready tied 1 -> 6 triples (0,9,18),(1,10,19),(2,11,20),(9,18,27),(10,19,28),(11,20,29), then done at the next cycle, err=0.
REQ-042 Same scan with addr_ready low for 3 cycles on the 2nd triple -> (1,10,19) held stable for 3 cycles, with no skip and no duplicate.
REQ-043 instr_fb=5 for 4 cycles mid-scan -> addr_valid low for 4 cycles, then the sequence resumes at the frozen index.
REQ-044 base=4080, n_cols=2, n_rows=3 -> triples (4080,4089,2) and (4081,4090,3), with err set at the first triple.
REQ-045 n_rows=2 -> no addr_valid, done 2 cycles after start, err=1; abort at the 3rd triple -> IDLE next cycle, with no done.
REQ-046 rst_n low asynchronously mid-scan -> all outputs 0 before the next edge; a new start then runs a clean scan.
